// File: rtl/parity_frame_pkg.sv
// Shared definitions for the parity frame transmitter and its receive-side peer.
package parity_frame_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Clock cycles from handshake to the end of the stop bit.
    function automatic int unsigned frame_len(input int unsigned data_w,
                                              input int unsigned clks_per_bit);
        return (data_w + 3) * clks_per_bit;
    endfunction

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/parity_frame_tx_acc.sv
// One-bit running-XOR parity accumulator, shared with the receive side.
module parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic load_val,
    input  logic en,
    input  logic bit_in,
    output logic acc,
    output logic acc_nxt_c
);

    logic acc_q;
    logic acc_d;

    // Load has priority; otherwise fold one bit in through the XOR cell.
    always_comb begin
        acc_d = acc_q;
        if (load) begin
            acc_d = load_val;
        end else if (en) begin
            acc_d = acc_q ^ bit_in;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc       = acc_q;
    assign acc_nxt_c = acc_d;

endmodule

// File: rtl/parity_frame_tx.sv
// LSB-first serial frame transmitter: start, data, running-XOR parity, stop.
module parity_frame_tx
    import parity_frame_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          ODD          = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out,
    output logic              busy,
    output logic              parity
);

    localparam int unsigned BIT_W  = cnt_width(DATA_W);
    localparam int unsigned BAUD_W = cnt_width(CLKS_PER_BIT);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                out_q, out_d;
    logic                busy_q, busy_d;
    logic                in_ready_q, in_ready_d;
    logic                acc_load, acc_en, acc_q, acc_nxt;
    logic                baud_last;

    assign baud_last = (baud_q == BAUD_LAST);

    parity_acc u_acc (
        .clk       (clk),
        .rst       (rst),
        .load      (acc_load),
        .load_val  (ODD),
        .en        (acc_en),
        .bit_in    (shift_q[0]),
        .acc       (acc_q),
        .acc_nxt_c (acc_nxt)
    );

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            out_q      <= 1'b1;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next state, bit timing and data-path updates.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        acc_load = 1'b0;
        acc_en   = 1'b0;
        if (state_q != ST_IDLE) begin
            baud_d = baud_last ? '0 : baud_q + BAUD_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shift_d  = in_data;
                    baud_d   = '0;
                    bit_d    = '0;
                    acc_load = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_last) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (baud_last) begin
                    acc_en  = 1'b1;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_last) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (baud_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the state being entered, so they register with it.
    always_comb begin
        out_d      = 1'b1;
        busy_d     = (state_d != ST_IDLE);
        in_ready_d = (state_d == ST_IDLE);
        case (state_d)
            ST_START:  out_d = 1'b0;
            ST_DATA:   out_d = shift_d[0];
            ST_PARITY: out_d = acc_nxt;
            default:   out_d = 1'b1;
        endcase
    end

    assign out      = out_q;
    assign busy     = busy_q;
    assign in_ready = in_ready_q;
    assign parity   = acc_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: three configurations checked against a frame-level model.
module tb_parity_frame_tx;
    import parity_frame_pkg::*;

    localparam int NDUT = 3;
    localparam int unsigned CPB_A [NDUT] = '{4, 4, 1};
    localparam int unsigned ODD_A [NDUT] = '{0, 1, 0};

    typedef logic [7:0] byte_q_t [$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] in_data_a  [NDUT] = '{8'h00, 8'h00, 8'h00};
    logic       in_valid_a [NDUT] = '{1'b0, 1'b0, 1'b0};
    logic       in_ready_a [NDUT];
    logic       out_a      [NDUT];
    logic       busy_a     [NDUT];
    logic       parity_a   [NDUT];

    int n_cmp = 0;
    int n_bad = 0;

    // Frame-level model state.
    bit         m_act  [NDUT];
    int         m_t    [NDUT];
    logic [7:0] m_word [NDUT];
    logic       m_last [NDUT] = '{1'b0, 1'b0, 1'b0};
    byte_q_t    exp_q  [NDUT];

    // Serial-line decoder state.
    bit          rx_on       [NDUT];
    int          rx_cnt      [NDUT];
    logic [10:0] rx_bits     [NDUT];
    logic [10:0] last_rx     [NDUT];
    int          frames_done [NDUT];

    always #5 clk = ~clk;

    parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .ODD(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .in_data(in_data_a[0]), .in_valid(in_valid_a[0]),
        .in_ready(in_ready_a[0]), .out(out_a[0]), .busy(busy_a[0]), .parity(parity_a[0]));
    parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .ODD(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_data_a[1]), .in_valid(in_valid_a[1]),
        .in_ready(in_ready_a[1]), .out(out_a[1]), .busy(busy_a[1]), .parity(parity_a[1]));
    parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .ODD(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .in_data(in_data_a[2]), .in_valid(in_valid_a[2]),
        .in_ready(in_ready_a[2]), .out(out_a[2]), .busy(busy_a[2]), .parity(parity_a[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Parity of the first n bits of w, seeded with odd.
    function automatic logic part_par(input logic [7:0] w, input int n, input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < n; i++) p = p ^ w[i];
        return p;
    endfunction

    // Line level during bit slot s of a frame carrying w.
    function automatic logic slot_val(input logic [7:0] w, input int s, input logic odd);
        if (s == 0) return 1'b0;
        if (s <= 8) return w[s-1];
        if (s == 9) return (^w) ^ odd;
        return 1'b1;
    endfunction

    // Model: track cycles since the accepted handshake of each instance.
    initial forever begin
        @(posedge clk or posedge rst);
        for (int k = 0; k < NDUT; k++) begin
            if (rst) begin
                m_act[k]  = 1'b0;
                m_t[k]    = 0;
                m_last[k] = 1'b0;
                exp_q[k].delete();
            end else if (m_act[k]) begin
                if (m_t[k] == int'(frame_len(8, CPB_A[k])) - 1) begin
                    m_act[k]  = 1'b0;
                    m_last[k] = (^m_word[k]) ^ 1'(ODD_A[k]);
                end else begin
                    m_t[k] = m_t[k] + 1;
                end
            end else if (in_valid_a[k]) begin
                m_act[k]  = 1'b1;
                m_t[k]    = 0;
                m_word[k] = in_data_a[k];
                exp_q[k].push_back(in_data_a[k]);
            end
        end
    end

    // Per-cycle compare against the model, plus a line decoder scoreboard.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            int s, cpb, flen, done_bits;
            logic odd, e_out, e_par, e_busy, e_rdy;
            logic [7:0] w;
            cpb  = int'(CPB_A[k]);
            flen = int'(frame_len(8, CPB_A[k]));
            odd  = 1'(ODD_A[k]);
            if (m_act[k]) begin
                s = m_t[k] / cpb;
                done_bits = (s == 0) ? 0 : ((s - 1 > 8) ? 8 : s - 1);
                e_out  = slot_val(m_word[k], s, odd);
                e_par  = part_par(m_word[k], done_bits, odd);
                e_busy = 1'b1;
                e_rdy  = 1'b0;
            end else begin
                e_out  = 1'b1;
                e_par  = m_last[k];
                e_busy = 1'b0;
                e_rdy  = 1'b1;
            end
            check($sformatf("dut%0d out", k),      32'(out_a[k]),      32'(e_out));
            check($sformatf("dut%0d busy", k),     32'(busy_a[k]),     32'(e_busy));
            check($sformatf("dut%0d in_ready", k), 32'(in_ready_a[k]), 32'(e_rdy));
            check($sformatf("dut%0d parity", k),   32'(parity_a[k]),   32'(e_par));

            if (rst) begin
                rx_on[k] = 1'b0;
            end else begin
                if (!rx_on[k] && out_a[k] == 1'b0) begin
                    rx_on[k]  = 1'b1;
                    rx_cnt[k] = 0;
                end
                if (rx_on[k]) begin
                    if (rx_cnt[k] % cpb == cpb / 2) rx_bits[k][rx_cnt[k] / cpb] = out_a[k];
                    if (rx_cnt[k] == flen - 1) begin
                        rx_on[k] = 1'b0;
                        w = rx_bits[k][8:1];
                        check($sformatf("dut%0d rx start", k), 32'(rx_bits[k][0]), 32'(1'b0));
                        check($sformatf("dut%0d rx stop", k),  32'(rx_bits[k][10]), 32'(1'b1));
                        check($sformatf("dut%0d rx parity", k), 32'(rx_bits[k][9]), 32'((^w) ^ odd));
                        if (exp_q[k].size() == 0) begin
                            check($sformatf("dut%0d rx unexpected frame", k), 32'(w), 32'hFFFF_FFFF);
                        end else begin
                            check($sformatf("dut%0d rx word", k), 32'(w), 32'(exp_q[k].pop_front()));
                        end
                        last_rx[k] = rx_bits[k];
                        frames_done[k] = frames_done[k] + 1;
                    end else begin
                        rx_cnt[k] = rx_cnt[k] + 1;
                    end
                end
            end
        end
    end

    // Present a word at the next in_ready; returns just after the handshake edge.
    task automatic send(input int k, input logic [7:0] d, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready_a[k] && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_a[k]) begin
            check($sformatf("dut%0d send timeout", k), 32'(in_ready_a[k]), 32'(1'b1));
            return;
        end
        #1;
        in_data_a[k]  = d;
        in_valid_a[k] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) in_valid_a[k] = 1'b0;
    endtask

    // Count clock edges until in_ready is seen high.
    task automatic wait_ready(input int k, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!in_ready_a[k] && cnt < 500);
        if (!in_ready_a[k])
            check($sformatf("dut%0d ready timeout", k), 32'(in_ready_a[k]), 32'(1'b1));
    endtask

    initial begin
        int c, target, cyc;
        logic [10:0] cap;

        repeat (3) @(negedge clk);
        #1;
        check("reset out",      32'(out_a[0]),      32'(1'b1));
        check("reset busy",     32'(busy_a[0]),     32'(1'b0));
        check("reset in_ready", 32'(in_ready_a[0]), 32'(1'b1));
        check("reset parity",   32'(parity_a[0]),   32'(1'b0));
        rst = 1'b0;

        // 0xA5, even parity, 4 clocks per bit.
        send(0, 8'hA5, 1'b0);
        check("A5 busy after handshake", 32'(busy_a[0]), 32'(1'b1));
        check("A5 out after handshake",  32'(out_a[0]),  32'(1'b0));
        wait_ready(0, c);
        check("A5 ready latency", 32'(c), 32'd44);
        check("A5 line bits", 32'(last_rx[0]), 32'(11'b10101001010));
        check("A5 parity", 32'(parity_a[0]), 32'(1'b0));

        // 0x07 with even and odd parity.
        send(0, 8'h07, 1'b0);
        send(1, 8'h07, 1'b0);
        wait_ready(0, c);
        wait_ready(1, c);
        check("07 even parity bit", 32'(last_rx[0][9]), 32'(1'b1));
        check("07 even parity out", 32'(parity_a[0]),   32'(1'b1));
        check("07 odd parity bit",  32'(last_rx[1][9]), 32'(1'b0));
        check("07 odd parity out",  32'(parity_a[1]),   32'(1'b0));

        // Back-to-back with in_valid held high: 0x01 then 0xFF.
        send(0, 8'h01, 1'b1);
        in_data_a[0] = 8'hFF;
        wait_ready(0, c);
        check("b2b ready latency", 32'(c), 32'd44);
        @(posedge clk);
        #1;
        check("b2b second handshake busy", 32'(busy_a[0]),     32'(1'b1));
        check("b2b second handshake rdy",  32'(in_ready_a[0]), 32'(1'b0));
        in_valid_a[0] = 1'b0;
        wait_ready(0, c);
        check("b2b second line bits", 32'(last_rx[0]), 32'(11'b10111111110));
        check("b2b second parity",    32'(parity_a[0]), 32'(1'b0));

        // Reset during the third data bit of 0x3C.
        send(0, 8'h3C, 1'b0);
        repeat (13) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst out",      32'(out_a[0]),      32'(1'b1));
        check("midrst busy",     32'(busy_a[0]),     32'(1'b0));
        check("midrst in_ready", 32'(in_ready_a[0]), 32'(1'b1));
        check("midrst parity",   32'(parity_a[0]),   32'(1'b0));
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        send(0, 8'h81, 1'b0);
        wait_ready(0, c);
        check("81 ready latency", 32'(c), 32'd44);
        check("81 line bits", 32'(last_rx[0]), 32'(11'b10100000010));

        // One clock per bit, 0x80.
        send(2, 8'h80, 1'b0);
        for (int i = 0; i < 11; i++) begin
            cap[i] = out_a[2];
            @(posedge clk);
            #1;
        end
        check("cpb1 line capture", 32'(cap), 32'(11'b11100000000));
        check("cpb1 ready after 11", 32'(in_ready_a[2]), 32'(1'b1));
        repeat (3) @(posedge clk);
        #1;
        check("cpb1 idle out",  32'(out_a[2]),    32'(1'b1));
        check("cpb1 parity",    32'(parity_a[2]), 32'(1'b1));

        // Random sweep: valid held high, data changing every cycle.
        target = frames_done[0] + 1000;
        cyc = 0;
        for (int k = 0; k < NDUT; k++) in_valid_a[k] = 1'b1;
        while (frames_done[0] < target && cyc < 60000) begin
            @(negedge clk);
            #1;
            for (int k = 0; k < NDUT; k++) in_data_a[k] = 8'($urandom);
            cyc++;
        end
        check("sweep frames reached", 32'(frames_done[0] >= target), 32'd1);
        for (int k = 0; k < NDUT; k++) in_valid_a[k] = 1'b0;
        for (int k = 0; k < NDUT; k++) wait_ready(k, c);
        repeat (4) @(posedge clk);
        for (int k = 0; k < NDUT; k++)
            check($sformatf("dut%0d queue drained", k), 32'(exp_q[k].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
